// File: rtl/rpn_pkg.sv
// Shared encodings and types for the RPN operand-stack controller.
package rpn_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [1:0] CMD_PUSH  = 2'b00;
    localparam logic [1:0] CMD_POP   = 2'b01;
    localparam logic [1:0] CMD_OP    = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;

    typedef enum logic [0:0] {
        StIdle,
        StExec
    } state_e;

    function automatic logic is_binary_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/rpn_stack_mem.sv
// Stack register file: one write port, combinational reads of entries depth-1 and depth-2.
module rpn_stack_mem
    import rpn_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [DW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [DW-1:0]    depth_i,
    output logic [WIDTH-1:0] rd_top_o,
    output logic [WIDTH-1:0] rd_next_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    top_idx;
    logic [DW-1:0]    next_idx;

    assign top_idx  = depth_i - DW'(1);
    assign next_idx = depth_i - DW'(2);

    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i < DW'(DEPTH))) begin
            mem_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    // Shallow stacks wrap the index past DEPTH; those reads return zero.
    assign rd_top_o  = (top_idx  < DW'(DEPTH)) ? mem_q[top_idx[AW-1:0]]  : '0;
    assign rd_next_o = (next_idx < DW'(DEPTH)) ? mem_q[next_idx[AW-1:0]] : '0;

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN operand-stack controller: command FSM, depth counter and ALU operand staging.
module rpn_stack_ctrl
    import rpn_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    input  logic [2:0]       cmd_aluop_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic [WIDTH-1:0] top_o,
    output logic [DW-1:0]    depth_o,
    output logic             done_o,
    output logic             err_o,
    output logic             err_sticky_o
);

    state_e           state_q;
    logic [DW-1:0]    depth_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_op_q;
    logic             unary_q;
    logic             done_q;
    logic             err_q;
    logic             err_sticky_q;

    logic             mem_we;
    logic [DW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] rd_top;
    logic [WIDTH-1:0] rd_next;

    logic accept;
    logic full;
    logic has_one;
    logic has_two;

    assign accept  = cmd_valid_i && (state_q == StIdle);
    assign full    = (depth_q >= DW'(DEPTH));
    assign has_one = (depth_q >= DW'(1));
    assign has_two = (depth_q >= DW'(2));

    // Write port serves both PUSH (at accept) and the ALU write-back (in EXEC);
    // reset suppresses either so an interrupted OP leaves no trace.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = depth_q;
        mem_wdata = cmd_data_i;
        if (!reset_i) begin
            if (state_q == StExec) begin
                mem_we    = 1'b1;
                mem_waddr = unary_q ? (depth_q - DW'(1)) : (depth_q - DW'(2));
                mem_wdata = alu_result_i;
            end else if (accept && (cmd_i == CMD_PUSH) && !full) begin
                mem_we = 1'b1;
            end
        end
    end

    rpn_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk_i     (clk_i),
        .we_i      (mem_we),
        .waddr_i   (mem_waddr),
        .wdata_i   (mem_wdata),
        .depth_i   (depth_q),
        .rd_top_o  (rd_top),
        .rd_next_o (rd_next)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            depth_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            unary_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        unique case (cmd_i)
                            CMD_PUSH: begin
                                if (!full) begin
                                    depth_q <= depth_q + DW'(1);
                                    done_q  <= 1'b1;
                                end else begin
                                    err_q        <= 1'b1;
                                    err_sticky_q <= 1'b1;
                                end
                            end
                            CMD_POP: begin
                                if (has_one) begin
                                    depth_q <= depth_q - DW'(1);
                                    done_q  <= 1'b1;
                                end else begin
                                    err_q        <= 1'b1;
                                    err_sticky_q <= 1'b1;
                                end
                            end
                            CMD_CLEAR: begin
                                depth_q      <= '0;
                                err_sticky_q <= 1'b0;
                                done_q       <= 1'b1;
                            end
                            CMD_OP: begin
                                if (is_binary_op(cmd_aluop_i) && has_two) begin
                                    alu_a_q  <= rd_next;
                                    alu_b_q  <= rd_top;
                                    alu_op_q <= cmd_aluop_i;
                                    unary_q  <= 1'b0;
                                    state_q  <= StExec;
                                end else if ((cmd_aluop_i == OP_NOT) && has_one) begin
                                    alu_a_q  <= rd_top;
                                    alu_b_q  <= '0;
                                    alu_op_q <= cmd_aluop_i;
                                    unary_q  <= 1'b1;
                                    state_q  <= StExec;
                                end else begin
                                    err_q        <= 1'b1;
                                    err_sticky_q <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StExec: begin
                    if (!unary_q) begin
                        depth_q <= depth_q - DW'(1);
                    end
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready_o  = (state_q == StIdle);
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_op_o     = alu_op_q;
    assign depth_o      = depth_q;
    assign top_o        = (depth_q == '0) ? '0 : rd_top;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Scoreboard bench for rpn_stack_ctrl with a behavioural ALU and stack model.
module tb_rpn_stack_ctrl;
    import rpn_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned D   = 8;
    localparam int unsigned DWL = 4;

    logic           clk;
    logic           reset;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd;
    logic [W-1:0]   cmd_data;
    logic [2:0]     cmd_aluop;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_result;
    logic [W-1:0]   top;
    logic [DWL-1:0] depth;
    logic           done;
    logic           err;
    logic           err_sticky;

    typedef struct {
        bit         ok;
        logic [7:0] top;
        int         depth;
        bit         sticky;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_checks;
    int         n_errors;
    logic [7:0] m_stk [D];
    int         m_depth;
    bit         m_sticky;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_NOT:  return ~a;
            OP_OR:   return a | b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    rpn_stack_ctrl #(
        .WIDTH (W),
        .DEPTH (D),
        .DW    (DWL)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_i        (cmd),
        .cmd_data_i   (cmd_data),
        .cmd_aluop_i  (cmd_aluop),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result),
        .top_o        (top),
        .depth_o      (depth),
        .done_o       (done),
        .err_o        (err),
        .err_sticky_o (err_sticky)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_top();
        return (m_depth == 0) ? 8'h00 : m_stk[m_depth-1];
    endfunction

    // Every done/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && (done || err)) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected_pulse", 32'(sb_q.size()), 32'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("sb_done", 32'(done), 32'(mon_e.ok));
                check_eq("sb_err", 32'(err), 32'(!mon_e.ok));
                check_eq("sb_top", 32'(top), 32'(mon_e.top));
                check_eq("sb_depth", 32'(depth), 32'(mon_e.depth));
                check_eq("sb_sticky", 32'(err_sticky), 32'(mon_e.sticky));
            end
        end
    end

    task automatic issue(input logic [1:0] c, input logic [7:0] data, input logic [2:0] op,
                         input bit rst_exec = 1'b0);
        exp_t       e;
        bit         ok;
        bit         go_exec;
        logic [7:0] ea;
        logic [7:0] eb;
        int         waited;
        ok      = 1'b1;
        go_exec = 1'b0;
        ea      = 8'h00;
        eb      = 8'h00;
        case (c)
            CMD_PUSH: begin
                if (m_depth < int'(D)) begin
                    m_stk[m_depth] = data;
                    m_depth++;
                end else begin
                    ok = 1'b0;
                end
            end
            CMD_POP: begin
                if (m_depth > 0) m_depth--;
                else ok = 1'b0;
            end
            CMD_CLEAR: begin
                m_depth  = 0;
                m_sticky = 1'b0;
            end
            default: begin
                if (is_binary_op(op) && m_depth >= 2) begin
                    go_exec = 1'b1;
                    ea      = m_stk[m_depth-2];
                    eb      = m_stk[m_depth-1];
                    if (!rst_exec) begin
                        m_stk[m_depth-2] = alu_f(ea, eb, op);
                        m_depth--;
                    end
                end else if (op == OP_NOT && m_depth >= 1) begin
                    go_exec = 1'b1;
                    ea      = m_stk[m_depth-1];
                    if (!rst_exec) m_stk[m_depth-1] = alu_f(ea, eb, op);
                end else begin
                    ok = 1'b0;
                end
            end
        endcase
        if (!ok) m_sticky = 1'b1;
        e = '{ok: ok, top: m_top(), depth: m_depth, sticky: m_sticky};
        if (!rst_exec) sb_q.push_back(e);

        cmd       = c;
        cmd_data  = data;
        cmd_aluop = op;
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check_eq("ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (go_exec) begin
            check_eq("exec_alu_a", 32'(alu_a), 32'(ea));
            check_eq("exec_alu_b", 32'(alu_b), 32'(eb));
            check_eq("exec_alu_op", 32'(alu_op), 32'(op));
            check_eq("exec_ready_low", 32'(cmd_ready), 32'd0);
            if (rst_exec) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                reset    = 1'b0;
                m_depth  = 0;
                m_sticky = 1'b0;
                check_eq("rst_exec_depth", 32'(depth), 32'd0);
                check_eq("rst_exec_top", 32'(top), 32'd0);
                check_eq("rst_exec_ready", 32'(cmd_ready), 32'd1);
                check_eq("rst_exec_done", 32'(done), 32'd0);
            end else begin
                @(posedge clk);
                @(negedge clk);
                check_eq("exec_ready_back", 32'(cmd_ready), 32'd1);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_depth   = 0;
        m_sticky  = 1'b0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd       = CMD_PUSH;
        cmd_data  = 8'h00;
        cmd_aluop = OP_ADD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check_eq("rst_depth", 32'(depth), 32'd0);
        check_eq("rst_top", 32'(top), 32'd0);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_alu_a", 32'(alu_a), 32'd0);
        check_eq("rst_alu_b", 32'(alu_b), 32'd0);
        check_eq("rst_alu_op", 32'(alu_op), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_sticky", 32'(err_sticky), 32'd0);

        issue(CMD_PUSH, 8'd5, OP_ADD);
        issue(CMD_PUSH, 8'd3, OP_ADD);
        issue(CMD_OP, 8'd0, OP_SUB);
        issue(CMD_CLEAR, 8'd0, OP_ADD);
        issue(CMD_PUSH, 8'd200, OP_ADD);
        issue(CMD_PUSH, 8'd100, OP_ADD);
        issue(CMD_OP, 8'd0, OP_ADD);
        issue(CMD_OP, 8'd0, OP_NOT);

        issue(CMD_CLEAR, 8'd0, OP_ADD);
        for (int i = 0; i < 8; i++) issue(CMD_PUSH, 8'(i * 37 + 5), OP_ADD);
        issue(CMD_PUSH, 8'd9, OP_ADD);
        issue(CMD_OP, 8'd0, OP_OR);
        issue(CMD_OP, 8'd0, OP_AND);
        issue(CMD_POP, 8'd0, OP_ADD);
        issue(CMD_CLEAR, 8'd0, OP_ADD);
        issue(CMD_POP, 8'd0, OP_ADD);
        issue(CMD_CLEAR, 8'd0, OP_ADD);

        issue(CMD_PUSH, 8'd7, OP_ADD);
        issue(CMD_OP, 8'd0, OP_ADD);
        issue(CMD_PUSH, 8'd9, OP_ADD);
        issue(CMD_OP, 8'd0, 3'b110);
        issue(CMD_OP, 8'd0, 3'b101);
        issue(CMD_OP, 8'd0, 3'b111);
        issue(CMD_CLEAR, 8'd0, OP_ADD);
        issue(CMD_OP, 8'd0, OP_NOT);

        issue(CMD_PUSH, 8'd10, OP_ADD);
        issue(CMD_PUSH, 8'd20, OP_ADD);
        issue(CMD_OP, 8'd0, OP_ADD, 1'b1);
        issue(CMD_PUSH, 8'd1, OP_ADD);
        issue(CMD_PUSH, 8'd250, OP_ADD);
        issue(CMD_OP, 8'd0, OP_ADD);

        repeat (2) @(negedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
